// File: rtl/spmv_vec_fetch.sv
// spmv_vec_fetch: AXI4 read master that fetches a contiguous run of 32-bit
// words for the SpMV kernel and replays them as an AXI-Stream.
// A command (byte base address, word count) is cut into INCR bursts that
// stay inside one 4 KB page and never exceed MAX_BURST beats. Only one
// burst is outstanding at a time. R data passes to the stream with zero
// latency, so stream backpressure is applied directly to the R channel.
// Optional build macro: SPMV_FETCH_ERRCHK_EN enables the sticky err flag
// (bad rresp or an rlast that disagrees with the internal beat count).
// When the macro is undefined, err is tied low.
module spmv_vec_fetch #(
    parameter logic [6:0] ID_VAL    = 7'd0,
    parameter int          MAX_BURST = 16,
    parameter int          LEN_W     = 16
) (
    input  logic             s_aclk,
    input  logic             s_aresetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [6:0]       m_axi_arid,
    output logic [31:0]      m_axi_araddr,
    output logic [7:0]       m_axi_arlen,
    output logic [2:0]       m_axi_arsize,
    output logic [1:0]       m_axi_arburst,
    output logic             m_axi_arvalid,
    input  logic             m_axi_arready,
    input  logic [6:0]       m_axi_rid,
    input  logic [31:0]      m_axi_rdata,
    input  logic [1:0]       m_axi_rresp,
    input  logic             m_axi_rlast,
    input  logic             m_axi_rvalid,
    output logic             m_axi_rready,
    output logic [31:0]      m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    logic [31:0]      r_addr;       // next word address to request
    logic [LEN_W-1:0] r_rem;        // words still owed for this command
    logic [8:0]       r_beat_cnt;   // beats left in the current burst (up to 256)
    logic             r_arvalid;
    logic [31:0]      r_araddr;
    logic [7:0]       r_arlen;
    logic             r_cmd_ready;
    logic             r_busy;
    logic             r_done;

    logic             w_cmd_acc;
    logic             w_in_wait;
    logic             w_r_hs;
    logic             w_last_beat;
    logic [10:0]      w_to_4k;
    logic [31:0]      w_beats;
    logic [7:0]       w_arlen;

    function automatic logic [31:0] min2(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

    assign w_cmd_acc   = cmd_valid && r_cmd_ready && (r_state == ST_IDLE);
    assign w_in_wait   = (r_state == ST_WAIT_R);
    assign w_r_hs      = w_in_wait && m_axi_rvalid && m_axis_tready;
    assign w_last_beat = (r_beat_cnt == 9'd1);

    // Burst size: smallest of words left, MAX_BURST and words to the next 4 KB page.
    always_comb begin
        w_to_4k = 11'd1024 - {1'b0, r_addr[11:2]};
        w_beats = min2(min2(32'(r_rem), 32'(MAX_BURST)), {21'd0, w_to_4k});
        w_arlen = 8'(w_beats - 32'd1);
    end

    // Command FSM with registered AR channel and status outputs.
    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            r_state     <= ST_IDLE;
            r_addr      <= 32'd0;
            r_rem       <= '0;
            r_beat_cnt  <= 9'd0;
            r_arvalid   <= 1'b0;
            r_araddr    <= 32'd0;
            r_arlen     <= 8'd0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    if (w_cmd_acc) begin
                        r_addr      <= {cmd_addr[31:2], 2'b00};
                        r_rem       <= cmd_len;
                        r_cmd_ready <= 1'b0;
                        if (cmd_len == '0) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_ISSUE;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    // AR fields are loaded once on entry and then held until accepted.
                    if (!r_arvalid) begin
                        r_arvalid <= 1'b1;
                        r_araddr  <= r_addr;
                        r_arlen   <= w_arlen;
                    end else if (m_axi_arready) begin
                        r_arvalid  <= 1'b0;
                        r_beat_cnt <= {1'b0, r_arlen} + 9'd1;
                        r_state    <= ST_WAIT_R;
                    end
                end
                ST_WAIT_R: begin
                    // Burst length follows the local beat counter, rlast is not trusted.
                    if (w_r_hs) begin
                        r_beat_cnt <= r_beat_cnt - 9'd1;
                        r_rem      <= r_rem - LEN_W'(1);
                        r_addr     <= r_addr + 32'd4;
                        if (w_last_beat) begin
                            if (r_rem != LEN_W'(1)) begin
                                r_state <= ST_ISSUE;
                            end else begin
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    r_done      <= 1'b1;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_arvalid   <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_cmd_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPMV_FETCH_ERRCHK_EN
    logic r_err;
    logic w_err_evt;
    logic w_unused_rid;

    assign w_err_evt    = w_r_hs && ((m_axi_rresp != 2'b00) || (m_axi_rlast != w_last_beat));
    assign w_unused_rid = ^m_axi_rid;

    // Sticky error flag, cleared when the next command is accepted.
    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            r_err <= 1'b0;
        end else if (w_cmd_acc) begin
            r_err <= 1'b0;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_sigs;

    assign w_unused_sigs = ^{m_axi_rid, m_axi_rresp, m_axi_rlast};
    assign err           = 1'b0;
`endif

    assign cmd_ready     = r_cmd_ready;
    assign busy          = r_busy;
    assign done          = r_done;

    assign m_axi_arid    = ID_VAL;
    assign m_axi_arsize  = 3'b010;
    assign m_axi_arburst = 2'b01;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arlen   = r_arlen;
    assign m_axi_arvalid = r_arvalid;

    // Zero-latency pass-through, only open while a burst is in flight.
    assign m_axi_rready  = w_in_wait && m_axis_tready;
    assign m_axis_tvalid = w_in_wait && m_axi_rvalid;
    assign m_axis_tdata  = w_in_wait ? m_axi_rdata : 32'd0;
    assign m_axis_tlast  = w_in_wait && (r_rem == LEN_W'(1));

endmodule

// File: tb/tb_spmv_vec_fetch.sv
// Directed bench for spmv_vec_fetch with an AXI read slave model and
// scoreboards for expected AR requests and expected stream words.
module tb_spmv_vec_fetch;

    localparam int         MAX_BURST = 16;
    localparam int         LEN_W     = 16;
    localparam logic [6:0] ID_VAL    = 7'd0;

    logic              s_aclk    = 1'b0;
    logic              s_aresetn = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [31:0]       cmd_addr  = 32'd0;
    logic [LEN_W-1:0]  cmd_len   = '0;
    logic [6:0]        m_axi_arid;
    logic [31:0]       m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic [2:0]        m_axi_arsize;
    logic [1:0]        m_axi_arburst;
    logic              m_axi_arvalid;
    logic              m_axi_arready = 1'b0;
    logic [6:0]        m_axi_rid     = 7'd0;
    logic [31:0]       m_axi_rdata   = 32'd0;
    logic [1:0]        m_axi_rresp   = 2'b00;
    logic              m_axi_rlast   = 1'b0;
    logic              m_axi_rvalid  = 1'b0;
    logic              m_axi_rready;
    logic [31:0]       m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b1;
    logic              m_axis_tlast;
    logic              busy;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_err    = 0;

    logic [39:0] exp_ar[$];   // {araddr, arlen}
    logic [32:0] exp_w[$];    // {tlast, tdata}

    // counters kept by the monitor
    int ar_valid_seen = 0;
    int tvalid_seen   = 0;
    int words_seen    = 0;
    int done_seen     = 0;

    // slave model configuration and state
    int          ar_delay    = 0;
    int          ar_cnt      = 0;
    logic [31:0] err_addr    = 32'hFFFF_FFFF;
    logic        tready_mode = 1'b0;
    logic        sl_active   = 1'b0;
    logic [31:0] sl_addr     = 32'd0;
    int          sl_left     = 0;

    // handshake flags captured at the negedge, consumed after the posedge
    logic        ar_fire_q = 1'b0;
    logic        r_fire_q  = 1'b0;
    logic [31:0] ar_addr_q = 32'd0;
    logic [7:0]  ar_len_q  = 8'd0;
    logic        ar_pend_q = 1'b0;
    logic [31:0] pend_addr = 32'd0;
    logic [7:0]  pend_len  = 8'd0;
    logic        prev_done = 1'b0;

    spmv_vec_fetch #(.ID_VAL(ID_VAL), .MAX_BURST(MAX_BURST), .LEN_W(LEN_W)) dut (
        .s_aclk(s_aclk), .s_aresetn(s_aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .busy(busy), .done(done), .err(err)
    );

    always #5 s_aclk = ~s_aclk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference split of a command into bursts and stream words.
    task automatic push_expected(input logic [31:0] addr, input int len);
        logic [31:0] a;
        int rem;
        a   = {addr[31:2], 2'b00};
        rem = len;
        while (rem > 0) begin
            int tok;
            int b;
            tok = (4096 - int'({20'd0, a[11:0]})) / 4;
            b   = rem;
            if (b > MAX_BURST) b = MAX_BURST;
            if (b > tok) b = tok;
            exp_ar.push_back({a, 8'(b - 1)});
            for (int i = 0; i < b; i++) begin
                exp_w.push_back({(rem == 1), memf(a)});
                a   = a + 32'd4;
                rem = rem - 1;
            end
        end
    endtask

    // Monitor: samples mid-cycle, checks AR and stream against the scoreboards.
    always @(negedge s_aclk) begin
        ar_fire_q = 1'b0;
        r_fire_q  = 1'b0;
        if (s_aresetn) begin
            if (ar_pend_q) begin
                chk("ar_hold_valid", m_axi_arvalid, 1);
                chk("ar_hold_addr", m_axi_araddr, pend_addr);
                chk("ar_hold_len", m_axi_arlen, pend_len);
            end
            ar_pend_q = m_axi_arvalid && !m_axi_arready;
            pend_addr = m_axi_araddr;
            pend_len  = m_axi_arlen;
            if (m_axi_arvalid) ar_valid_seen++;
            if (m_axi_arvalid && m_axi_arready) begin
                ar_fire_q = 1'b1;
                ar_addr_q = m_axi_araddr;
                ar_len_q  = m_axi_arlen;
                chk("ar_expected", exp_ar.size() != 0, 1);
                if (exp_ar.size() != 0) begin
                    logic [39:0] e;
                    e = exp_ar.pop_front();
                    chk("araddr", m_axi_araddr, e[39:8]);
                    chk("arlen", m_axi_arlen, e[7:0]);
                end
            end
            if (m_axi_rvalid) chk("rready_track", m_axi_rready, m_axis_tready);
            if (m_axi_rvalid && m_axi_rready) r_fire_q = 1'b1;
            if (m_axis_tvalid) begin
                tvalid_seen++;
                chk("busy_in_stream", busy, 1);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                words_seen++;
                chk("w_expected", exp_w.size() != 0, 1);
                if (exp_w.size() != 0) begin
                    logic [32:0] e;
                    e = exp_w.pop_front();
                    chk("tdata", m_axis_tdata, e[31:0]);
                    chk("tlast", m_axis_tlast, e[32]);
                end
            end
            if (done) begin
                done_seen++;
                chk("busy_at_done", busy, 0);
                chk("done_one_cycle", prev_done, 0);
            end
            prev_done = done;
        end else begin
            ar_pend_q = 1'b0;
            prev_done = 1'b0;
        end
    end

    // AXI read slave model: delayed arready, one burst at a time, data from memf.
    always @(posedge s_aclk) begin
        #1;
        if (!s_aresetn) begin
            m_axi_arready = 1'b0;
            m_axi_rvalid  = 1'b0;
            m_axi_rlast   = 1'b0;
            m_axi_rresp   = 2'b00;
            sl_active     = 1'b0;
            ar_cnt        = 0;
        end else begin
            if (r_fire_q) begin
                sl_left = sl_left - 1;
                sl_addr = sl_addr + 32'd4;
                if (sl_left == 0) begin
                    m_axi_rvalid = 1'b0;
                    m_axi_rlast  = 1'b0;
                    sl_active    = 1'b0;
                end else begin
                    m_axi_rdata = memf(sl_addr);
                    m_axi_rlast = (sl_left == 1);
                    m_axi_rresp = (sl_addr == err_addr) ? 2'b10 : 2'b00;
                end
            end
            if (ar_fire_q) begin
                m_axi_arready = 1'b0;
                ar_cnt        = 0;
                sl_active     = 1'b1;
                sl_addr       = ar_addr_q;
                sl_left       = int'(ar_len_q) + 1;
                m_axi_rvalid  = 1'b1;
                m_axi_rdata   = memf(sl_addr);
                m_axi_rlast   = (sl_left == 1);
                m_axi_rresp   = (sl_addr == err_addr) ? 2'b10 : 2'b00;
            end else if (m_axi_arvalid && !m_axi_arready && !sl_active) begin
                if (ar_cnt >= ar_delay) m_axi_arready = 1'b1;
                else ar_cnt = ar_cnt + 1;
            end
        end
    end

    // Stream consumer: always ready, or toggling every cycle.
    always @(posedge s_aclk) begin
        #1;
        if (tready_mode) m_axis_tready = ~m_axis_tready;
        else m_axis_tready = 1'b1;
    end

    task automatic start_cmd(input logic [31:0] a, input int l);
        int n;
        @(posedge s_aclk);
        #1;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = LEN_W'(l);
        n = 0;
        @(negedge s_aclk);
        while (!cmd_ready && n < 100) begin
            @(negedge s_aclk);
            n++;
        end
        chk("cmd_accept", cmd_ready, 1);
        @(posedge s_aclk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        int n;
        n = 0;
        do begin
            @(negedge s_aclk);
            n++;
        end while (!done && n < 3000);
        chk("done_seen", done, 1);
        cycles = n;
    endtask

    task automatic run_cmd(input logic [31:0] a, input int l);
        int d0;
        int cyc;
        d0 = done_seen;
        push_expected(a, l);
        start_cmd(a, l);
        wait_done(cyc);
        repeat (3) @(negedge s_aclk);
        chk("done_count", 64'(done_seen - d0), 1);
        chk("ar_queue_empty", 64'(exp_ar.size()), 0);
        chk("w_queue_empty", 64'(exp_w.size()), 0);
        chk("err_clear", err, 0);
    endtask

    initial begin
        int cyc;
        int av0;
        int tv0;
        int w0;
        int n;

        // reset state
        repeat (3) @(negedge s_aclk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_rready", m_axi_rready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_araddr", m_axi_araddr, 0);
        chk("arid", m_axi_arid, ID_VAL);
        chk("arsize", m_axi_arsize, 3'b010);
        chk("arburst", m_axi_arburst, 2'b01);
        s_aresetn = 1'b1;
        repeat (2) @(negedge s_aclk);
        chk("idle_cmd_ready", cmd_ready, 1);

        // three bursts, last one short
        run_cmd(32'h0000_0100, 40);
        // 4 KB page split
        run_cmd(32'h0000_0FF0, 8);

        // zero-length command
        av0 = ar_valid_seen;
        tv0 = tvalid_seen;
        start_cmd(32'h0000_0800, 0);
        wait_done(cyc);
        chk("len0_done_latency", 64'(cyc), 2);
        repeat (3) @(negedge s_aclk);
        chk("len0_no_arvalid", 64'(ar_valid_seen - av0), 0);
        chk("len0_no_tvalid", 64'(tvalid_seen - tv0), 0);

        // backpressure and slow arready, unaligned low address bits
        ar_delay    = 3;
        tready_mode = 1'b1;
        run_cmd(32'h0000_0303, 5);
        ar_delay    = 0;
        tready_mode = 1'b0;

`ifdef SPMV_FETCH_ERRCHK_EN
        // bad response on beat 2 of 4
        err_addr = 32'h0000_0404;
        push_expected(32'h0000_0400, 4);
        start_cmd(32'h0000_0400, 4);
        wait_done(cyc);
        repeat (3) @(negedge s_aclk);
        chk("err_sticky", err, 1);
        chk("err_words", 64'(exp_w.size()), 0);
        err_addr = 32'hFFFF_FFFF;
        push_expected(32'h0000_0500, 1);
        start_cmd(32'h0000_0500, 1);
        @(negedge s_aclk);
        chk("err_cleared_on_accept", err, 0);
        wait_done(cyc);
        repeat (3) @(negedge s_aclk);
`else
        chk("err_tied_low", err, 0);
`endif

        // reset in the middle of a burst
        w0 = words_seen;
        push_expected(32'h0000_0600, 20);
        start_cmd(32'h0000_0600, 20);
        n = 0;
        while (words_seen < w0 + 3 && n < 200) begin
            @(negedge s_aclk);
            n++;
        end
        chk("midburst_reached", words_seen >= w0 + 3, 1);
        @(negedge s_aclk);
        #2;
        s_aresetn = 1'b0;
        #1;
        chk("mid_rst_tvalid", m_axis_tvalid, 0);
        chk("mid_rst_rready", m_axi_rready, 0);
        chk("mid_rst_arvalid", m_axi_arvalid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        exp_ar.delete();
        exp_w.delete();
        repeat (2) @(negedge s_aclk);
        s_aresetn = 1'b1;
        repeat (2) @(negedge s_aclk);
        run_cmd(32'h0000_0200, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/spmv_vec_fetch.md
Name: spmv_vec_fetch

Overview:
AXI4 read master that fetches a contiguous vector of 32-bit words from the on-chip AXI block RAM in the SpMV kernel.
- Takes one command (byte base address, word count) at a time.
- Splits it into INCR bursts that never cross a 4 KB boundary and never exceed MAX_BURST beats.
- Streams the returned words out as AXI-Stream, with tlast on the final word of the command.
- Sits directly upstream of the block RAM's AR/R channels and feeds the SpMV multiply datapath.

Parameters:
ID_VAL, 0, constant value driven on m_axi_arid (7 bits)
MAX_BURST, 16, maximum beats per burst; power of two, 1..256
LEN_W, 16, width of the command word-count field

Ports:
s_aclk  in  1  clock
s_aresetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_addr  in  32  byte base address; bits [1:0] ignored (treated as 0)
cmd_len  in  LEN_W  number of 32-bit words to fetch
m_axi_arid  out  7  read ID, constant ID_VAL
m_axi_araddr  out  32  burst start byte address
m_axi_arlen  out  8  beats-1
m_axi_arsize  out  3  constant 3'b010
m_axi_arburst  out  2  constant 2'b01 (INCR)
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_rid  in  7  read ID (ignored)
m_axi_rdata  in  32  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  last beat of burst
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready
m_axis_tdata  out  32  vector word
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tlast  out  1  final word of command
busy  out  1  high from command accept until the DONE state
done  out  1  one-cycle pulse when a command completes
err  out  1  sticky error flag; cleared on the next command accept

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0 except the constants arid/arsize/arburst. Reset mid-burst abandons the command; no pending state survives.
- FSM states:
  - IDLE: cmd_ready=1. On accept, latch addr = {cmd_addr[31:2],2'b00} and rem = cmd_len; clear err. If cmd_len==0, go to DONE with no AR issued; otherwise go to ISSUE.
  - ISSUE: compute beats = min(rem, MAX_BURST, (4096 - addr[11:0])/4). Register araddr=addr, arlen=beats-1, and assert arvalid starting the cycle after entry. Hold araddr/arlen stable until arready. On the handshake, load the beat counter with beats and go to WAIT_R.
  - WAIT_R: one outstanding burst only. m_axi_rready = m_axis_tready; m_axis_tvalid = m_axi_rvalid; tdata = rdata. This is a combinational pass-through with zero latency.
    - Each R handshake decrements the beat counter and rem, and adds 4 to addr.
    - tlast=1 on the beat where rem goes 1->0.
    - When the beat counter hits 0: if rem!=0, return to ISSUE; else go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0; go to IDLE.
- cmd_ready=0 in every state except IDLE.
- Burst count is governed only by the internal beat counter, never by rlast.
- Address arithmetic: 32-bit, wraps modulo 2^32 with no error.
- rready and tvalid are held 0 outside WAIT_R. Stray R beats outside WAIT_R are not accepted.
- Backpressure: a tready low stall holds rready low; data is never dropped or duplicated.

Optional Feature:
SPMV_FETCH_ERRCHK_EN
- Defined: err is set when either of these occurs:
  - an accepted beat has rresp != 2'b00;
  - rlast disagrees with (beat counter == 1).
  The transfer still completes per the beat counter.
- Undefined: err is tied 0, and rresp/rlast are unused.

Test Plan:
- cmd_addr=0x0000_0100, cmd_len=40, MAX_BURST=16, always ready -> three ARs: (0x100, arlen 15), (0x140, arlen 15), (0x180, arlen 7); 40 stream beats; tlast only on beat 40; done pulses once.
- cmd_addr=0x0000_0FF0, cmd_len=8 -> ARs (0xFF0, arlen 3) then (0x1000, arlen 3); no burst crosses 4 KB.
- cmd_len=0 -> no arvalid ever; done pulses 2 cycles after the accept; no tvalid.
- cmd_len=5, tready toggles 1/0 every cycle and arready is delayed 3 cycles -> araddr/arlen stable while waiting; exactly 5 words delivered in order; rready tracks tready.
- With SPMV_FETCH_ERRCHK_EN: rresp=2'b10 on beat 2 of 4 -> err=1 sticky, 4 words still delivered, done pulses. The next command accept clears err to 0.
- Assert s_aresetn low in the middle of WAIT_R -> all valids drop immediately. After release, a new command cmd_addr=0x200, cmd_len=1 yields a single AR (0x200, arlen 0) and one tlast beat.
